// File: rtl/onchip_rd_pkg.sv
// onchip_rd_pkg: shared state encoding and default sizes for the on-chip memory stream reader
package onchip_rd_pkg;
    localparam int ADDR_W_DEF     = 18;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_DEPTH_DEF  = 217088;
    localparam int FIFO_DEPTH_DEF = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} rd_state_e;
endpackage

// File: rtl/onchip_rd_fifo.sv
// onchip_rd_fifo: synchronous show-ahead FIFO with occupancy count
//   clk/reset : clock, sync active-high reset (flushes contents)
//   i_push/i_wdata : write side; i_pop : consume head word
//   o_rdata : head word (zero when empty); o_count : words held
module onchip_rd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic [CW-1:0]     o_count
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_count;
    logic              w_push, w_pop;
    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_rdata = (r_count != '0) ? r_mem[r_rp] : '0;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_wdata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader: reads a block of words from on-chip memory and streams them out in order
//   clk/reset : clock, sync active-high reset
//   start/start_addr/length : launch a transfer; busy/done/err : status
//   address..readdata : read-only memory master, fixed 1-cycle read latency
//   st_data/st_valid/st_ready : valid/ready output stream
//   ONCHIP_RD_BOUND_CHK_EN : when defined, out-of-range requests set err and issue no reads
module onchip_mem_stream_reader
    import onchip_rd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(MEM_DEPTH - 1);

    rd_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_remain, w_remain_nxt;
    logic              r_inflight;
    logic [CW-1:0]     w_count;
    logic              w_room, w_bad;

    assign write      = 1'b0;
    assign writedata  = '0;
    assign byteenable = 4'hF;
    assign clken      = 1'b1;
    assign address    = r_addr;
    assign st_valid   = (w_count != '0);
    // Room is judged against words held plus the read still in flight, so a
    // returning word always has a slot even if the consumer stalls.
    assign w_room     = (w_count + CW'(r_inflight)) < CW'(FIFO_DEPTH);

`ifdef ONCHIP_RD_BOUND_CHK_EN
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    logic [ADDR_W:0] w_end;
    logic            r_err;
    assign w_end = {1'b0, start_addr} + {1'b0, length};
    assign w_bad = ({1'b0, start_addr} >= LP_DEPTH) || (w_end > LP_DEPTH);
    assign err   = r_err;
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else if (r_state == ST_IDLE && start) r_err <= w_bad;
    end
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    onchip_rd_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_wdata (readdata),
        .i_pop   (st_valid && st_ready),
        .o_rdata (st_data),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_remain   <= w_remain_nxt;
            r_inflight <= chipselect;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        chipselect   = 1'b0;
        busy         = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
        done         = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: if (start) begin
                w_addr_nxt   = start_addr;
                w_remain_nxt = length;
                w_state_nxt  = (w_bad || length == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                chipselect = w_room;
                if (w_room) begin
                    w_addr_nxt   = (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
                    w_remain_nxt = r_remain - 1'b1;
                    if (r_remain == ADDR_W'(1)) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (!r_inflight && w_count == '0) w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// tb_onchip_mem_stream_reader: scoreboard bench for the on-chip memory stream reader
module tb_onchip_mem_stream_reader;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int MD = 217088;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          st_ready = 1'b1;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] length = '0;
    logic [DW-1:0] readdata = '0;
    logic          busy, done, err, chipselect, write, clken, st_valid;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic [DW-1:0] writedata, st_data;

    always #5 clk = ~clk;

    onchip_mem_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .err(err), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .write(write), .writedata(writedata), .clken(clken),
        .readdata(readdata), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[13:0], a} ^ 32'h5A5A_0000;
    endfunction

    // Memory model: one-cycle read latency, garbage when not selected.
    always @(posedge clk) readdata <= chipselect ? mem_word(address) : 32'hDEAD_BEEF;

    int n_chk = 0, n_fail = 0, n_cs = 0, n_words = 0, n_done = 0;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];
    logic          p_stall = 1'b0;
    logic [DW-1:0] p_data = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                check("stall_valid", st_valid, 1);
                check("stall_data", st_data, p_data);
            end
            if (chipselect) begin
                n_cs++;
                if (addr_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_read: got address %0h expected no read", address);
                end else check("read_addr", address, addr_q.pop_front());
            end
            if (st_valid && st_ready) begin
                n_words++;
                if (data_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_word: got %0h expected no word", st_data);
                end else check("stream_data", st_data, data_q.pop_front());
            end
            if (done) n_done++;
            p_stall = st_valid && !st_ready;
            p_data  = st_data;
        end
    end

    task automatic expect_xfer(input logic [AW-1:0] sa, input int len);
        logic [AW-1:0] a;
        a = sa;
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(a);
            data_q.push_back(mem_word(a));
            a = (a == AW'(MD - 1)) ? '0 : a + 1'b1;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] sa, input logic [AW-1:0] len);
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; length = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < budget);
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("addr_q_empty", addr_q.size(), 0);
        check("data_q_empty", data_q.size(), 0);
        addr_q.delete();
        data_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cs"}, chipselect, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_st_valid"}, st_valid, 0);
        check({tag, "_st_data"}, st_data, 0);
    endtask

    initial begin
        int cyc, k, cs0, w0, d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check("const_write", write, 0);
        check("const_writedata", writedata, 0);
        check("const_byteenable", byteenable, 4'hF);
        check("const_clken", clken, 1);
        @(posedge clk); #1 reset = 1'b0;

        // Basic 8-word read at full throughput.
        expect_xfer(18'h100, 8);
        cs0 = n_cs;
        pulse_start(18'h100, 8);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!st_valid && k < 3);
        check("first_valid_latency", st_valid, 1);
        wait_done(40, cyc);
        check("t1_reads", n_cs - cs0, 8);
        check("t1_throughput", (k + cyc) <= 13, 1);

        // Stalled consumer: reads must stop at the buffer depth.
        st_ready = 1'b0;
        expect_xfer(18'h0A0, 16);
        cs0 = n_cs;
        pulse_start(18'h0A0, 16);
        repeat (20) @(negedge clk);
        check("t2_stall_reads_le4", (n_cs - cs0) <= 4, 1);
        check("t2_stall_valid", st_valid, 1);
        check("t2_stall_busy", busy, 1);
        @(posedge clk); #1 st_ready = 1'b1;
        wait_done(80, cyc);
        check("t2_reads", n_cs - cs0, 16);

        // Zero-length transfer.
        cs0 = n_cs;
        pulse_start(18'h055, 0);
        wait_done(5, cyc);
        check("t3_latency", cyc, 1);
        check("t3_reads", n_cs - cs0, 0);

        // Transfer crossing the top of memory.
        cs0 = n_cs;
`ifdef ONCHIP_RD_BOUND_CHK_EN
        pulse_start(18'd217086, 4);
        wait_done(10, cyc);
        check("t4_err", err, 1);
        check("t4_reads", n_cs - cs0, 0);
`else
        expect_xfer(18'd217086, 4);
        pulse_start(18'd217086, 4);
        wait_done(30, cyc);
        check("t4_err", err, 0);
        check("t4_reads", n_cs - cs0, 4);
`endif

        // Reset in the middle of a 10-word transfer.
        expect_xfer(18'h3000, 10);
        w0 = n_words;
        d0 = n_done;
        pulse_start(18'h3000, 10);
        check("err_clear_on_start", err, 0);
        k = 0;
        while ((n_words - w0) < 5 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_word5", (n_words - w0) >= 5, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        addr_q.delete();
        data_q.delete();
        @(negedge clk);
        check_reset_outputs("t5");
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_done", n_done - d0, 0);
        check("t5_idle_cs", chipselect, 0);
        expect_xfer(18'h300, 3);
        cs0 = n_cs;
        pulse_start(18'h300, 3);
        wait_done(30, cyc);
        check("t5_reads_after", n_cs - cs0, 3);

        // Start re-pulsed while busy must be ignored.
        expect_xfer(18'h400, 6);
        cs0 = n_cs;
        pulse_start(18'h400, 6);
        start = 1'b1; start_addr = 18'h010; length = 18'd2;
        @(posedge clk); #1 start = 1'b0;
        wait_done(40, cyc);
        check("t6_reads", n_cs - cs0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "timeout");
    end
endmodule
